uart_rx_to_fifo: RTL and testbench

Receive-side bridge. Takes byte strobes from `uart_rx` and pushes them into the command FIFO that feeds the JTAG command decoder. It holds one byte locally while the FIFO is full or a write is in flight, discards framing-errored bytes, and counts overflow drops. An optional line-idle detector marks the end of a command burst.

---
 rtl/uart_bridge_pkg.sv | 14 +
 rtl/uart_idle_timer.sv | 54 +++++
 rtl/uart_rx_to_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_rx_to_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and defaults for the UART receive-to-FIFO bridge.
package uart_bridge_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } rx_fifo_state_e;

    // 10 character times at 115200 baud with a 50 MHz clock
    localparam int unsigned IDLE_CYCLES_DEFAULT = 43400;

endpackage

// File: rtl/uart_idle_timer.sv
// Line-idle detector: counts silence after rx_valid and pulses rx_idle once per armed burst.
module uart_idle_timer
    import uart_bridge_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_valid,
    input  logic rx_accept,
    output logic rx_idle
);

    localparam int unsigned CNT_W = $clog2(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arm_q, arm_d;
    logic             idle_q, idle_d;
    logic             fire;

    always_comb begin
        fire   = arm_q && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        arm_d  = arm_q;
        idle_d = fire;
        if (rx_valid) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // a new accepted byte re-arms even if the pulse fires this cycle
        if (rx_accept) begin
            arm_d = 1'b1;
        end else if (fire) begin
            arm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            arm_q  <= 1'b0;
            idle_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            arm_q  <= arm_d;
            idle_q <= idle_d;
        end
    end

    assign rx_idle = idle_q;

endmodule

// File: rtl/uart_rx_to_fifo.sv
// Bridges uart_rx byte strobes into the command FIFO with a one-byte hold buffer and drop stats.
// Optional line-idle pulse is built when UART_RX_IDLE_DETECT_EN is defined.
module uart_rx_to_fifo
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DROP_W      = 8,
    parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_frame_err,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [7:0]        fifo_wr_data,
    output logic              overflow,
    output logic              frame_err,
    output logic [DROP_W-1:0] drop_count,
    input  logic              stat_clr,
    output logic              rx_idle
);

    if (IDLE_CYCLES < 2) begin : g_bad_idle
        $error("IDLE_CYCLES must be at least 2");
    end

    rx_fifo_state_e    state_q, state_d;
    byte_t             hold_q, hold_d;
    byte_t             wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              overflow_q, overflow_d;
    logic              frame_err_q, frame_err_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              drop;

    logic accept;
    logic errored;
    logic slot;

    // never writing back-to-back keeps a one-cycle-stale fifo_full safe
    assign accept  = rx_valid && !rx_frame_err;
    assign errored = rx_valid && rx_frame_err;
    assign slot    = !fifo_full && !wr_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept && !slot) state_d = HELD;
            HELD:  if (slot && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        drop      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept && slot) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rx_data;
                end else if (accept) begin
                    hold_d = rx_data;
                end
            end
            HELD: begin
                if (slot) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = hold_q;
                    if (accept) hold_d = rx_data;
                end else if (accept) begin
                    drop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // statistics: a same-cycle event wins over stat_clr
    always_comb begin
        overflow_d  = (stat_clr ? 1'b0 : overflow_q) | drop;
        frame_err_d = (stat_clr ? 1'b0 : frame_err_q) | errored;
        drop_d      = drop_q;
        if (drop) begin
            if (stat_clr)           drop_d = DROP_W'(1);
            else if (drop_q != '1)  drop_d = drop_q + DROP_W'(1);
        end else if (stat_clr) begin
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            hold_q      <= hold_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            drop_q      <= drop_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;
    assign drop_count   = drop_q;

`ifdef UART_RX_IDLE_DETECT_EN
    uart_idle_timer #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_idle_timer (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_accept (accept),
        .rx_idle   (rx_idle)
    );
`else
    assign rx_idle = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_to_fifo.sv
// Directed self-checking bench for uart_rx_to_fifo (idle checks depend on UART_RX_IDLE_DETECT_EN).
module tb_uart_rx_to_fifo;

    localparam int unsigned DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_frame_err;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [7:0]        fifo_wr_data;
    logic              overflow;
    logic              frame_err;
    logic [DROP_W-1:0] drop_count;
    logic              stat_clr;
    logic              rx_idle;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;

    uart_rx_to_fifo #(
        .DROP_W      (DROP_W),
        .IDLE_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .drop_count   (drop_count),
        .stat_clr     (stat_clr),
        .rx_idle      (rx_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic err);
        rx_data      = d;
        rx_valid     = 1'b1;
        rx_frame_err = err;
        tick();
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},  32'(fifo_wr_en),   32'h0);
        chk({tag, "_data"},   32'(fifo_wr_data), 32'h0);
        chk({tag, "_ovf"},    32'(overflow),     32'h0);
        chk({tag, "_ferr"},   32'(frame_err),    32'h0);
        chk({tag, "_drops"},  32'(drop_count),   32'h0);
        chk({tag, "_idle"},   32'(rx_idle),      32'h0);
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_frame_err = 1'b0;
        fifo_full = 1'b0; stat_clr = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // single byte, one-cycle latency
        send(8'hA5, 1'b0);
        chk("a5_wr_en", 32'(fifo_wr_en), 32'h1);
        chk("a5_data",  32'(fifo_wr_data), 32'hA5);
        tick();
        chk("a5_wr_pulse", 32'(fifo_wr_en), 32'h0);
        chk("a5_ovf",   32'(overflow),   32'h0);
        chk("a5_ferr",  32'(frame_err),  32'h0);
        chk("a5_drops", 32'(drop_count), 32'h0);

        // byte held while FIFO full, written after release
        fifo_full = 1'b1;
        send(8'h11, 1'b0);
        chk("hold_no_wr", 32'(fifo_wr_en), 32'h0);
        cnt = 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (fifo_wr_en) cnt++;
        end
        chk("hold_writes_while_full", 32'(cnt), 32'h0);
        fifo_full = 1'b0;
        tick();
        chk("hold_release_wr", 32'(fifo_wr_en), 32'h1);
        chk("hold_release_data", 32'(fifo_wr_data), 32'h11);
        tick();
        chk("hold_single_wr", 32'(fifo_wr_en), 32'h0);
        chk("hold_no_ovf", 32'(overflow), 32'h0);

        // overflow: 0x22/0x33 dropped, 0x11 kept
        fifo_full = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_drops", 32'(drop_count), 32'h2);
        fifo_full = 1'b0;
        tick();
        chk("ovf_wr", 32'(fifo_wr_en), 32'h1);
        chk("ovf_data", 32'(fifo_wr_data), 32'h11);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fifo_wr_en) cnt++;
        end
        chk("ovf_no_extra_wr", 32'(cnt), 32'h0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'h0);
        chk("clr_drops", 32'(drop_count), 32'h0);

        // framing error discarded, next byte normal
        send(8'h55, 1'b1);
        chk("ferr_no_wr", 32'(fifo_wr_en), 32'h0);
        chk("ferr_flag", 32'(frame_err), 32'h1);
        tick();
        chk("ferr_still_no_wr", 32'(fifo_wr_en), 32'h0);
        send(8'h66, 1'b0);
        chk("after_ferr_wr", 32'(fifo_wr_en), 32'h1);
        chk("after_ferr_data", 32'(fifo_wr_data), 32'h66);
        tick();

        // drop in the same cycle as stat_clr: event wins
        fifo_full = 1'b1;
        send(8'h77, 1'b0);
        rx_data = 8'h88; rx_valid = 1'b1; stat_clr = 1'b1;
        tick();
        rx_valid = 1'b0; stat_clr = 1'b0;
        chk("clr_drop_ovf", 32'(overflow), 32'h1);
        chk("clr_drop_cnt", 32'(drop_count), 32'h1);
        chk("clr_drop_ferr_cleared", 32'(frame_err), 32'h0);
        fifo_full = 1'b0;
        tick();
        chk("clr_drop_wr_data", 32'(fifo_wr_data), 32'h77);
        chk("clr_drop_wr_en", 32'(fifo_wr_en), 32'h1);
        tick();
        rx_data = 8'h99; rx_valid = 1'b1; rx_frame_err = 1'b1; stat_clr = 1'b1;
        tick();
        rx_valid = 1'b0; rx_frame_err = 1'b0; stat_clr = 1'b0;
        chk("clr_ferr_flag", 32'(frame_err), 32'h1);
        chk("clr_ferr_ovf", 32'(overflow), 32'h0);
        chk("clr_ferr_drops", 32'(drop_count), 32'h0);
        chk("clr_ferr_no_wr", 32'(fifo_wr_en), 32'h0);

        // back-to-back bytes: second held one cycle, order kept
        rx_data = 8'h01; rx_valid = 1'b1;
        tick();
        chk("b2b_wr1", 32'(fifo_wr_en), 32'h1);
        chk("b2b_data1", 32'(fifo_wr_data), 32'h01);
        rx_data = 8'h02;
        tick();
        rx_valid = 1'b0;
        chk("b2b_gap", 32'(fifo_wr_en), 32'h0);
        tick();
        chk("b2b_wr2", 32'(fifo_wr_en), 32'h1);
        chk("b2b_data2", 32'(fifo_wr_data), 32'h02);
        tick();
        chk("b2b_end", 32'(fifo_wr_en), 32'h0);

        // drop counter saturation
        fifo_full = 1'b1;
        send(8'hAA, 1'b0);
        for (int i = 0; i < 300; i++) send(8'hBB, 1'b0);
        chk("sat_drops", 32'(drop_count), 32'hFF);
        chk("sat_ovf", 32'(overflow), 32'h1);
        fifo_full = 1'b0;
        tick();
        chk("sat_kept_oldest", 32'(fifo_wr_data), 32'hAA);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("sat_clr", 32'(drop_count), 32'h0);

        // idle pulse 8 cycles after the last accepted byte, then none
        send(8'hC3, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef UART_RX_IDLE_DETECT_EN
            chk($sformatf("idle_k%0d", k), 32'(rx_idle), (k == 8) ? 32'h1 : 32'h0);
`else
            chk($sformatf("idle_off_k%0d", k), 32'(rx_idle), 32'h0);
`endif
        end
        send(8'h5A, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_idle) cnt++;
        end
        chk("idle_not_rearmed_by_err", 32'(cnt), 32'h0);

        // reset while HELD discards the byte and clears everything
        fifo_full = 1'b1;
        send(8'hDE, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        tick();
        rst = 1'b0;
        fifo_full = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fifo_wr_en) cnt++;
        end
        chk("midrst_no_wr", 32'(cnt), 32'h0);
        send(8'hF0, 1'b0);
        chk("midrst_recover_data", 32'(fifo_wr_data), 32'hF0);
        chk("midrst_recover_wr", 32'(fifo_wr_en), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
